// File: rtl/pipelined_rformat_cpu_pkg.sv
// rfcpu_pkg: shared definitions for the pipelined R-format CPU.
//   OP_RTYPE / FUNCT_* : instruction encodings
//   alu_op_t           : decoded ALU operation (ALU_NONE = no register write)
//   fx_reg_t, xw_ctl_t : F/X and X/W pipeline-register layouts
//   decode_funct()     : funct field -> ALU operation
package rfcpu_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'h00;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;

    typedef enum logic [3:0] {
        ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_t;

    // F/X register: the fetched instruction word and whether the slot is live.
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
    } fx_reg_t;

    // X/W register control half; the result word is kept beside it because
    // its width follows the XLEN parameter of the instantiating module.
    typedef struct packed {
        logic       valid;
        logic       we;
        logic [4:0] rd;
    } xw_ctl_t;

    function automatic alu_op_t decode_funct(input logic [5:0] funct);
        case (funct)
            FUNCT_ADD: return ALU_ADD;
            FUNCT_SUB: return ALU_SUB;
            FUNCT_AND: return ALU_AND;
            FUNCT_OR:  return ALU_OR;
            FUNCT_XOR: return ALU_XOR;
            FUNCT_NOR: return ALU_NOR;
            FUNCT_SLT: return ALU_SLT;
            FUNCT_SLL: return ALU_SLL;
            FUNCT_SRL: return ALU_SRL;
            FUNCT_SRA: return ALU_SRA;
            default:   return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/pipelined_rformat_cpu_if.sv
// CPU bus: instruction fetch, hold/preload control and retirement report.
//   master (CPU side): drives pc_out, wb_valid, wb_addr, wb_data, retire_cnt;
//                      receives instr_in, hold, init_we, init_addr, init_data.
//   slave (environment side): the mirror image.
interface pipelined_rformat_cpu_if #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic [PC_W-1:0]  pc_out;
    logic [31:0]      instr_in;
    logic             hold;
    logic             init_we;
    logic [4:0]       init_addr;
    logic [XLEN-1:0]  init_data;
    logic             wb_valid;
    logic [4:0]       wb_addr;
    logic [XLEN-1:0]  wb_data;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output pc_out, wb_valid, wb_addr, wb_data, retire_cnt,
        input  instr_in, hold, init_we, init_addr, init_data
    );

    modport slave (
        input  pc_out, wb_valid, wb_addr, wb_data, retire_cnt,
        output instr_in, hold, init_we, init_addr, init_data
    );
endinterface

// File: rtl/pipelined_rformat_cpu_rf_bank.sv
// rf_bank: NREG x XLEN register file, two async read ports, one sync write.
//   clk, rst_n            : clock, synchronous active-low reset (clears all)
//   ra1/ra2 -> rd1/rd2    : read ports; r0 and indices >= NREG read 0
//   we, wa, wd            : pipeline write port, used while hold=0
//   hold, init_*          : preload port, used instead while hold=1
module rf_bank #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    input  logic            hold,
    input  logic            init_we,
    input  logic [4:0]      init_addr,
    input  logic [XLEN-1:0] init_data
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [XLEN-1:0] regs [NREG];
    logic            w_en;
    logic [4:0]      w_addr;
    logic [XLEN-1:0] w_data;

    // r0 and indices beyond the implemented file are not backed by storage.
    function automatic logic backed(input logic [4:0] a);
        return (a != 5'd0) && (int'(a) < NREG);
    endfunction

    assign rd1 = backed(ra1) ? regs[ra1[AW-1:0]] : '0;
    assign rd2 = backed(ra2) ? regs[ra2[AW-1:0]] : '0;

    // The pipeline never writes while held, so hold alone selects the source.
    // NOTE: every always_comb output gets a value on every path, else a latch is inferred.
    always_comb begin
        w_en   = we;
        w_addr = wa;
        w_data = wd;
        if (hold) begin
            w_en   = init_we;
            w_addr = init_addr;
            w_data = init_data;
        end
    end

    // NOTE: this storage is reset on purpose because architectural state must read 0 after reset; plain RAMs normally are not reset.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (w_en && backed(w_addr)) begin
            regs[w_addr[AW-1:0]] <= w_data;
        end
    end
endmodule

// File: rtl/pipelined_rformat_cpu.sv
// pipelined_rformat_cpu: 3-stage (fetch / execute / writeback) R-format CPU.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fetch address/instruction, hold and preload control,
//                retirement report (wb_valid/wb_addr/wb_data) and retire_cnt
module pipelined_rformat_cpu
    import rfcpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int PC_W    = 32,
    parameter int PC_STEP = 4,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic rst_n,
    pipelined_rformat_cpu_if.master bus
);
    logic [PC_W-1:0]  pc_q;
    fx_reg_t          fx_q;
    xw_ctl_t          xw_q;
    logic [XLEN-1:0]  xw_data_q;
    logic [CNT_W-1:0] cnt_q;

    // X-stage decode
    logic [4:0] rs, rt, rd, shamt;
    logic [5:0] funct;
    logic       is_rtype;
    alu_op_t    op;
    logic       x_we;
    logic [4:0] x_rd;

    assign rs       = fx_q.instr[25:21];
    assign rt       = fx_q.instr[20:16];
    assign rd       = fx_q.instr[15:11];
    assign shamt    = fx_q.instr[10:6];
    assign funct    = fx_q.instr[5:0];
    assign is_rtype = (fx_q.instr[31:26] == OP_RTYPE);
    assign op       = is_rtype ? decode_funct(funct) : ALU_NONE;
    // we marks a write that actually lands in the RF; forwarding relies on it.
    assign x_we     = (op != ALU_NONE) && (rd != 5'd0) && (int'(rd) < NREG);
    // Non-R-type bubbles report rd=0.
    assign x_rd     = is_rtype ? rd : 5'd0;

    // Register read with W->X forwarding of the instruction retiring this cycle
    logic [XLEN-1:0] rf_a, rf_b, op_a, op_b, x_result;
    logic            fwd_a, fwd_b;

    rf_bank #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra1       (rs),
        .ra2       (rt),
        .rd1       (rf_a),
        .rd2       (rf_b),
        .we        (xw_q.valid & xw_q.we),
        .wa        (xw_q.rd),
        .wd        (xw_data_q),
        .hold      (bus.hold),
        .init_we   (bus.init_we),
        .init_addr (bus.init_addr),
        .init_data (bus.init_data)
    );

    assign fwd_a = xw_q.valid && xw_q.we && (xw_q.rd == rs);
    assign fwd_b = xw_q.valid && xw_q.we && (xw_q.rd == rt);
    assign op_a  = fwd_a ? xw_data_q : rf_a;
    assign op_b  = fwd_b ? xw_data_q : rf_b;

    // Shifts of XLEN or more fall out of the operators: 0 for <<, >>, sign fill for >>>.
    always_comb begin
        x_result = '0;
        case (op)
            ALU_ADD: x_result = op_a + op_b;
            ALU_SUB: x_result = op_a - op_b;
            ALU_AND: x_result = op_a & op_b;
            ALU_OR:  x_result = op_a | op_b;
            ALU_XOR: x_result = op_a ^ op_b;
            ALU_NOR: x_result = ~(op_a | op_b);
            ALU_SLT: x_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLL: x_result = op_b << shamt;
            ALU_SRL: x_result = op_b >> shamt;
            ALU_SRA: x_result = $signed(op_b) >>> shamt;
            default: x_result = '0;
        endcase
    end

    // Pipeline registers: reset wins, then hold freezes everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= '0;
            fx_q      <= '0;
            xw_q      <= '0;
            xw_data_q <= '0;
            cnt_q     <= '0;
        end else if (!bus.hold) begin
            pc_q      <= pc_q + PC_W'(PC_STEP);
            fx_q      <= '{valid: 1'b1, instr: bus.instr_in};
            xw_q      <= '{valid: fx_q.valid, we: fx_q.valid & x_we, rd: x_rd};
            xw_data_q <= x_result;
            if (xw_q.valid) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.pc_out     = pc_q;
    assign bus.wb_valid   = xw_q.valid & ~bus.hold;
    assign bus.wb_addr    = xw_q.rd;
    assign bus.wb_data    = xw_data_q;
    assign bus.retire_cnt = cnt_q;
endmodule

// File: tb/tb_pipelined_rformat_cpu.sv
// Self-checking bench for pipelined_rformat_cpu: a directed vector table
// (with and without a mid-stream hold), a reset-with-instructions-in-flight
// sequence followed by a full register readback, and random programs checked
// against a sequential (unpipelined) reference model.
module tb_pipelined_rformat_cpu;
    localparam int CNT_W = 4;
    localparam logic [31:0] BUBBLE = 32'hFC00_0000;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  addr;
        logic [31:0] data;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_rformat_cpu_if #(.XLEN(32), .PC_W(32), .CNT_W(CNT_W)) bus ();

    pipelined_rformat_cpu #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Asynchronous-read instruction memory
    logic [31:0] prog [256];
    assign bus.instr_in = prog[bus.pc_out[9:2]];

    logic [31:0] m_rf [32];
    logic [4:0]  exp_addr [64];
    logic [31:0] exp_data [64];
    vec_t        tbl [17];
    logic [5:0]  functs [11];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Architectural (sequential) execution of one instruction.
    function automatic void model_exec(input logic [31:0] ins, output logic [4:0] a, output logic [31:0] d);
        logic [31:0] x, y;
        int sh;
        a = 5'd0;
        d = 32'd0;
        if (ins[31:26] != 6'd0) return;
        x  = m_rf[ins[25:21]];
        y  = m_rf[ins[20:16]];
        sh = int'(ins[10:6]);
        a  = ins[15:11];
        case (ins[5:0])
            6'h20: d = x + y;
            6'h22: d = x - y;
            6'h24: d = x & y;
            6'h25: d = x | y;
            6'h26: d = x ^ y;
            6'h27: d = ~(x | y);
            6'h2A: d = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            6'h00: d = y << sh;
            6'h02: d = y >> sh;
            6'h03: d = $signed(y) >>> sh;
            default: return;
        endcase
        if (a != 5'd0) m_rf[a] = d;
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = BUBBLE;
    endtask

    // Reset with hold asserted; leaves the bench at a negedge, pipe empty and held.
    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        bus.hold = 1'b1;
        bus.init_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset pc_out", bus.pc_out, 0);
        check("reset wb_valid", bus.wb_valid, 0);
        check("reset wb_addr", bus.wb_addr, 0);
        check("reset wb_data", bus.wb_data, 0);
        check("reset retire_cnt", bus.retire_cnt, 0);
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        bus.init_we = 1'b1;
        bus.init_addr = a;
        bus.init_data = d;
        @(posedge clk);
        @(negedge clk);
        bus.init_we = 1'b0;
        if (a != 5'd0) m_rf[a] = d;
    endtask

    // Runs prog from pc=0 until n instructions have retired. The k-th
    // unheld edge fetches instruction k-1, which retires during the cycle
    // after unheld edge k+1; retire_cnt counts earlier retirements.
    task automatic run_pipe(input int n, input int hold_at, input int hold_len, input string tag);
        int e;
        int cyc;
        int ret;
        logic exp_v;
        e = 0;
        cyc = 0;
        bus.hold = 1'b0;
        while (e < n + 1 || bus.hold) begin
            @(posedge clk);
            if (!bus.hold) e++;
            @(negedge clk);
            cyc++;
            exp_v = !bus.hold && (e >= 2);
            ret = (e >= 2) ? e - 2 : 0;
            check($sformatf("%s pc c%0d", tag, cyc), bus.pc_out, 64'(e * 4));
            check($sformatf("%s wb_valid c%0d", tag, cyc), bus.wb_valid, exp_v);
            if (exp_v && (e - 2) < n) begin
                check($sformatf("%s wb_addr i%0d", tag, e - 2), bus.wb_addr, exp_addr[e-2]);
                check($sformatf("%s wb_data i%0d", tag, e - 2), bus.wb_data, exp_data[e-2]);
            end
            check($sformatf("%s retire_cnt c%0d", tag, cyc), bus.retire_cnt, 64'(ret % (1 << CNT_W)));
            bus.hold = (hold_at >= 0) && (cyc >= hold_at) && (cyc < hold_at + hold_len);
            if (cyc > n + 64) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s timeout: got %0d retired, expected %0d", tag, ret, n);
                break;
            end
        end
        bus.hold = 1'b1;
    endtask

    task automatic run_table(input int hold_at, input int hold_len, input string tag);
        reset_dut();
        preload(5'd0, 32'h0000_1234);
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd3);
        preload(5'd6, 32'h8000_0000);
        clear_prog();
        for (int i = 0; i < 17; i++) begin
            prog[i]     = tbl[i].instr;
            exp_addr[i] = tbl[i].addr;
            exp_data[i] = tbl[i].data;
        end
        run_pipe(17, hold_at, hold_len, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.hold = 1'b1;
        bus.init_we = 1'b0;
        bus.init_addr = 5'd0;
        bus.init_data = 32'd0;
        clear_prog();

        // Preloads: r0<-0x1234 (dropped), r1=5, r2=3, r6=0x80000000
        tbl[0]  = '{32'h0022_1820, 5'd3,  32'd8};          // add r3,r1,r2
        tbl[1]  = '{32'h0061_2022, 5'd4,  32'd3};          // sub r4,r3,r1 (fwd rs)
        tbl[2]  = '{32'h0022_0020, 5'd0,  32'd8};          // add r0,r1,r2 (dropped)
        tbl[3]  = '{32'h0000_1820, 5'd3,  32'd0};          // add r3,r0,r0 (no fwd of r0)
        tbl[4]  = '{32'h0002_2900, 5'd5,  32'd48};         // sll r5,r2,4
        tbl[5]  = '{32'h0006_3903, 5'd7,  32'hF800_0000};  // sra r7,r6,4
        tbl[6]  = '{32'h0006_4102, 5'd8,  32'h0800_0000};  // srl r8,r6,4
        tbl[7]  = '{32'h0083_4822, 5'd9,  32'd3};          // sub r9,r4,r3 (RF)
        tbl[8]  = '{32'h00E2_502A, 5'd10, 32'd1};          // slt r10,r7,r2 (signed)
        tbl[9]  = '{BUBBLE,        5'd0,  32'd0};          // non-R-type bubble
        tbl[10] = '{32'h0020_5827, 5'd11, 32'hFFFF_FFFA};  // nor r11,r1,r0
        tbl[11] = '{32'h0022_603F, 5'd12, 32'd0};          // unsupported funct
        tbl[12] = '{32'h0161_6826, 5'd13, 32'hFFFF_FFFF};  // xor r13,r11,r1 (dist 2)
        tbl[13] = '{32'h01A2_7024, 5'd14, 32'd3};          // and r14,r13,r2 (fwd)
        tbl[14] = '{32'h01CC_7825, 5'd15, 32'd3};          // or r15,r14,r12
        tbl[15] = '{32'h0002_87C0, 5'd16, 32'h8000_0000};  // sll r16,r2,31
        tbl[16] = '{32'h0030_8820, 5'd17, 32'h8000_0005};  // add r17,r1,r16 (fwd rt)

        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h3F};

        run_table(-1, 0, "vec");
        run_table(5, 3, "vec_hold");

        // Reset with two instructions in flight: neither may reach the RF.
        reset_dut();
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd3);
        clear_prog();
        prog[0] = 32'h0022_1820;
        prog[1] = 32'h0061_2022;
        bus.hold = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("inflight wb_valid", bus.wb_valid, 1);
        check("inflight wb_data", bus.wb_data, 8);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset pc_out", bus.pc_out, 0);
        check("midreset wb_valid", bus.wb_valid, 0);
        check("midreset retire_cnt", bus.retire_cnt, 0);
        check("midreset wb_data", bus.wb_data, 0);
        rst_n = 1'b1;
        bus.hold = 1'b1;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        // Read back every register with or rk,rk,r0; a preload attempt
        // while running (hold=0) must be ignored.
        clear_prog();
        for (int k = 0; k < 32; k++) begin
            prog[k]     = (32'(k) << 21) | (32'(k) << 11) | 32'h25;
            exp_addr[k] = 5'(k);
            exp_data[k] = 32'd0;
        end
        bus.init_we = 1'b1;
        bus.init_addr = 5'd20;
        bus.init_data = 32'hDEAD_BEEF;
        run_pipe(32, -1, 0, "readback");
        bus.init_we = 1'b0;

        // Random programs against the sequential model
        for (int r = 0; r < 4; r++) begin
            logic [4:0]  a;
            logic [31:0] d;
            logic [31:0] ins;
            reset_dut();
            for (int k = 1; k < 8; k++) preload(5'(k), $urandom);
            clear_prog();
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    ins = {6'($urandom_range(1, 63)), 26'($urandom)};
                end else begin
                    ins = {6'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                           5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                           functs[$urandom_range(0, 10)]};
                end
                prog[i] = ins;
                model_exec(ins, a, d);
                exp_addr[i] = a;
                exp_data[i] = d;
            end
            run_pipe(40, $urandom_range(2, 30), $urandom_range(1, 4), $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
